// File: rtl/iob_ram_port_arbiter_pkg.sv
// Shared memory-port definitions: byte width, strobe count and grant-index width helpers.
package iob_ram_port_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_kind_e;

  function automatic int unsigned nstrb(input int unsigned dataW);
    return dataW / BYTE_W;
  endfunction

  function automatic int unsigned idxW(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N.
module iob_rr_arbiter
  import iob_ram_port_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [idxW(N)-1:0]   ptr,
  output logic [N-1:0]         grant,
  output logic [idxW(N)-1:0]   idx,
  output logic                 valid
);

  localparam int unsigned IDX_W = idxW(N);

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned cand;
      cand = (32'(ptr) + k) % N;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_ram_port_arbiter.sv
// Round-robin arbiter multiplexing N_MST native masters onto one read-first BRAM port.
module iob_ram_port_arbiter
  import iob_ram_port_arbiter_pkg::*;
#(
  parameter int unsigned N_MST  = 2,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_MST-1:0]                   m_valid,
  input  logic [N_MST*ADDR_W-1:0]            m_addr,
  input  logic [N_MST*DATA_W-1:0]            m_wdata,
  input  logic [N_MST*nstrb(DATA_W)-1:0]     m_wstrb,
  output logic [N_MST-1:0]                   m_ready,
  output logic [N_MST-1:0]                   m_rvalid,
  output logic [DATA_W-1:0]                  m_rdata,
  output logic                               ram_en,
  output logic [nstrb(DATA_W)-1:0]           ram_we,
  output logic [ADDR_W-1:0]                  ram_addr,
  output logic [DATA_W-1:0]                  ram_din,
  input  logic [DATA_W-1:0]                  ram_dout
);

  localparam int unsigned NSTRB = nstrb(DATA_W);
  localparam int unsigned IDX_W = idxW(N_MST);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gntIdx;
  logic [IDX_W-1:0] rdId;
  logic [N_MST-1:0] reqMasked;
  logic [N_MST-1:0] gntOneHot;
  logic             gntValid;
  logic             rdPend;
  acc_kind_e        selKind;

  // Masking requests during reset is what keeps grant, ready and ram_en low.
  assign reqMasked = rst ? '0 : m_valid;

  iob_rr_arbiter #(
    .N (N_MST)
  ) uArb (
    .req   (reqMasked),
    .ptr   (ptr),
    .grant (gntOneHot),
    .idx   (gntIdx),
    .valid (gntValid)
  );

  always_comb begin
    m_ready  = gntOneHot;
    ram_en   = gntValid;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    selKind  = ACC_READ;
    if (gntValid) begin
      ram_we   = m_wstrb[gntIdx*NSTRB +: NSTRB];
      ram_addr = m_addr[gntIdx*ADDR_W +: ADDR_W];
      ram_din  = m_wdata[gntIdx*DATA_W +: DATA_W];
      selKind  = (|m_wstrb[gntIdx*NSTRB +: NSTRB]) ? ACC_WRITE : ACC_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= IDX_W'(N_MST - 1);
      rdPend <= 1'b0;
      rdId   <= '0;
    end else begin
      if (gntValid) begin
        ptr <= gntIdx;
      end
      rdPend <= gntValid && (selKind == ACC_READ);
      rdId   <= gntIdx;
    end
  end

  // Gating with rst drops a read accepted just before reset asserts.
  always_comb begin
    m_rvalid = '0;
    if (rdPend && !rst) begin
      m_rvalid[rdId] = 1'b1;
    end
  end

  assign m_rdata = ram_dout;

endmodule

// File: tb/tb_iob_ram_port_arbiter.sv
// Bench for iob_ram_port_arbiter with a read-first byte-enable BRAM model and a reference model.
module tb_iob_ram_port_arbiter;

  localparam int N = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_valid;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*SW-1:0]   m_wstrb;
  logic [N-1:0]      m_ready;
  logic [N-1:0]      m_rvalid;
  logic [DW-1:0]     m_rdata;
  logic              ram_en;
  logic [SW-1:0]     ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_dout;

  int testCnt = 0;
  int failCnt = 0;

  iob_ram_port_arbiter #(
    .N_MST  (N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM port: read-first, byte write enables, preloadable from refMem.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] refMem [0:(1<<AW)-1];
  logic          preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= refMem[i];
    end else if (ram_en) begin
      ram_dout <= mem[ram_addr];
      for (int b = 0; b < SW; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
  end

  // Reference model state: rotation pointer and the read response owed next cycle.
  int            modelPtr;
  logic          expPend;
  int            expId;
  logic [DW-1:0] expData;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp)
    else begin
      failCnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] v,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [SW-1:0] s0, input logic [SW-1:0] s1);
    logic [N-1:0]  eRv;
    logic [N-1:0]  eRdy;
    logic [AW-1:0] aArr [N];
    logic [DW-1:0] dArr [N];
    logic [SW-1:0] sArr [N];
    int g;
    @(negedge clk);
    rst = r; m_valid = v;
    m_addr = {a1, a0}; m_wdata = {d1, d0}; m_wstrb = {s1, s0};
    aArr[0] = a0; aArr[1] = a1; dArr[0] = d0; dArr[1] = d1; sArr[0] = s0; sArr[1] = s1;
    #1;
    eRv = (!r && expPend) ? N'(1 << expId) : '0;
    chk("rvalid", 64'(m_rvalid), 64'(eRv));
    if (eRv != '0) chk("rdata", 64'(m_rdata), 64'(expData));
    g = -1;
    if (!r) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (modelPtr + k) % N;
        if (g < 0 && v[c]) g = c;
      end
    end
    eRdy = (g >= 0) ? N'(1 << g) : '0;
    chk("ready", 64'(m_ready), 64'(eRdy));
    chk("ram_en", 64'(ram_en), 64'(g >= 0));
    chk("ram_we", 64'(ram_we), (g >= 0) ? 64'(sArr[g]) : 64'(0));
    chk("ram_addr", 64'(ram_addr), (g >= 0) ? 64'(aArr[g]) : 64'(0));
    chk("ram_din", 64'(ram_din), (g >= 0) ? 64'(dArr[g]) : 64'(0));
    if (r) begin
      modelPtr = N - 1;
      expPend = 1'b0;
      expId = 0;
    end else if (g >= 0) begin
      expPend = (sArr[g] == '0);
      expId = g;
      expData = refMem[aArr[g]];
      for (int b = 0; b < SW; b++)
        if (sArr[g][b]) refMem[aArr[g]][b*8 +: 8] = dArr[g][b*8 +: 8];
      modelPtr = g;
    end else begin
      expPend = 1'b0;
    end
  endtask

  initial begin
    logic [1:0]    prevRdy;
    logic [1:0]    invRdy;
    logic [1:0]    rv;
    logic [AW-1:0] ra0, ra1;
    logic [SW-1:0] rs0, rs1;
    rst = 1'b1; m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    modelPtr = N - 1; expPend = 1'b0; expId = 0; expData = '0;
    for (int i = 0; i < (1 << AW); i++) refMem[i] = $urandom;
    preload = 1'b1;

    // 1: reset held with all masters requesting
    step(1, 2'b11, 10'h001, 10'h002, '0, '0, '0, '0);
    preload = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1, 2'b11, 10'h001, 10'h002, '0, '0, '0, '0);
      chk("rst_ready", 64'(m_ready), 64'(0));
      chk("rst_en", 64'(ram_en), 64'(0));
    end
    step(0, 2'b11, 10'h001, 10'h002, '0, '0, '0, '0);
    chk("rst_first_grant", 64'(m_ready), 64'(2'b01));
    chk("rst_first_rvalid", 64'(m_rvalid), 64'(0));

    // 2: master1 write then read of the same address
    step(0, 2'b10, '0, 10'h005, '0, 32'hDEADBEEF, '0, 4'hF);
    step(0, 2'b10, '0, 10'h005, '0, '0, '0, '0);
    step(0, 2'b00, '0, '0, '0, '0, '0, '0);
    chk("wr_rd_rvalid", 64'(m_rvalid), 64'(2'b10));
    chk("wr_rd_data", 64'(m_rdata), 64'(32'hDEADBEEF));

    // 3: partial strobe at the top address
    step(0, 2'b01, 10'h3FF, '0, 32'h11223344, '0, 4'hF, '0);
    step(0, 2'b01, 10'h3FF, '0, 32'h0000AB00, '0, 4'b0010, '0);
    step(0, 2'b01, 10'h3FF, '0, '0, '0, '0, '0);
    step(0, 2'b00, '0, '0, '0, '0, '0, '0);
    chk("partial_rvalid", 64'(m_rvalid), 64'(2'b01));
    chk("partial_data", 64'(m_rdata), 64'(32'h1122AB44));

    // 4: continuous contention alternates grants with no idle cycles
    prevRdy = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 2'b11, AW'(10'h020 + i), AW'(10'h040 + i), '0, '0, '0, '0);
      chk("cont_en", 64'(ram_en), 64'(1));
      if (i > 0) begin
        invRdy = ~prevRdy;
        chk("cont_alt", 64'(m_ready), 64'(invRdy));
        chk("cont_rvalid", 64'(m_rvalid), 64'(prevRdy));
      end
      prevRdy = m_ready;
    end

    // 5: reset straight after an accepted read
    step(0, 2'b01, 10'h007, '0, '0, '0, '0, '0);
    chk("midrst_accept", 64'(m_ready), 64'(2'b01));
    step(1, 2'b00, '0, '0, '0, '0, '0, '0);
    chk("midrst_rv_rst", 64'(m_rvalid), 64'(0));
    step(1, 2'b00, '0, '0, '0, '0, '0, '0);
    step(0, 2'b00, '0, '0, '0, '0, '0, '0);
    chk("midrst_rv_after", 64'(m_rvalid), 64'(0));
    step(0, 2'b11, 10'h008, 10'h009, '0, '0, '0, '0);
    chk("midrst_ptr", 64'(m_ready), 64'(2'b01));

    // 6: withdrawn request leaves no trace
    step(0, 2'b10, '0, 10'h00A, '0, '0, '0, '0);
    step(0, 2'b11, 10'h00B, 10'h00C, '0, '0, '0, '0);
    chk("wd_m0_granted", 64'(m_ready), 64'(2'b01));
    step(0, 2'b00, '0, 10'h00C, '0, '0, '0, '0);
    chk("wd_no_access", 64'(ram_en), 64'(0));
    step(0, 2'b00, '0, '0, '0, '0, '0, '0);
    chk("wd_no_rvalid", 64'(m_rvalid), 64'(0));

    // Randomized traffic over a small address window for frequent read-after-write
    for (int i = 0; i < 300; i++) begin
      rv  = 2'($urandom);
      ra0 = ($urandom_range(0, 3) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 3) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
      rs0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      rs1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(($urandom_range(0, 39) == 0), rv, ra0, ra1, $urandom, $urandom, rs0, rs1);
    end
    step(0, 2'b00, '0, '0, '0, '0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
